bank_arbiter: RTL and testbench

//  Downstream of the 16 per-bank schedulers: picks one bank request per cycle and registers it for the

---
 rtl/bank_arbiter_pkg.sv | 37 +++
 rtl/bank_arbiter_rr_pick.sv | 35 +++
 rtl/bank_arbiter.sv | 122 ++++++++++++
 tb/tb_bank_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// bank_arbiter_pkg : shared widths, the bank request record and an encoder
// Revision: 1.0
// ============================================================================
package bank_arbiter_pkg;

  localparam int BANK_NUM   = 16;
  localparam int DQ         = 16;
  localparam int IDX        = 6;
  localparam int RA         = 16;
  localparam int CA         = 10;
  localparam int STARVE_MAX = 8;

  localparam int BANK_BITS  = $clog2(BANK_NUM);
  localparam int AGE_BITS   = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic            req_type;
    logic [DQ-1:0]   data;
    logic [IDX-1:0]  idx;
    logic [RA-1:0]   row;
    logic [CA-1:0]   column;
  } bank_req_t;

  // OR-reduction encoder; the input is guaranteed one-hot or zero.
  function automatic logic [BANK_BITS-1:0] onehot_to_idx(input logic [BANK_NUM-1:0] oh);
    logic [BANK_BITS-1:0] res;
    res = '0;
    for (int i = 0; i < BANK_NUM; i++) begin
      if (oh[i]) res = res | BANK_BITS'(i);
    end
    return res;
  endfunction

endpackage : bank_arbiter_pkg
`default_nettype wire

// File: rtl/bank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// bank_arbiter_rr_pick : one-hot round-robin pick starting at ptr
// Revision: 1.0
// ============================================================================
module bank_arbiter_rr_pick
  import bank_arbiter_pkg::*;
#(
  parameter int N  = BANK_NUM,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] below;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // The upper copy of req supplies the wrapped-around candidates, so the
  // lowest surviving bit above ptr is the round-robin winner.
  always_comb begin
    dbl    = {req, req};
    below  = ((2*N)'(1) << ptr) - (2*N)'(1);
    masked = dbl & ~below;
    lowest = masked & (~masked + (2*N)'(1));
    grant  = lowest[N-1:0] | lowest[2*N-1:N];
    any    = |req;
  end

endmodule : bank_arbiter_rr_pick
`default_nettype wire

// File: rtl/bank_arbiter.sv
`default_nettype none
// ============================================================================
// bank_arbiter : per-cycle bank pick (starved > row-hit > any, round-robin),
//                registered output slot, open-row table and starvation ages
// Revision: 1.0
// ============================================================================
module bank_arbiter
  import bank_arbiter_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BANK_NUM-1:0]           valid_i,
  input  logic [BANK_NUM-1:0][DQ-1:0]   dq_i,
  input  logic [BANK_NUM-1:0][IDX-1:0]  idx_i,
  input  logic [BANK_NUM-1:0][RA-1:0]   ra_i,
  input  logic [BANK_NUM-1:0][CA-1:0]   ca_i,
  input  logic [BANK_NUM-1:0]           t_i,
  output logic [BANK_NUM-1:0]           ready_o,
  input  logic                          flush_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [BANK_BITS-1:0]          bank_o,
  output logic [DQ-1:0]                 dq_o,
  output logic [IDX-1:0]                idx_o,
  output logic [RA-1:0]                 ra_o,
  output logic [CA-1:0]                 ca_o,
  output logic                          t_o,
  output logic                          hit_o
);

  logic [RA-1:0]        open_row [BANK_NUM];
  logic [BANK_NUM-1:0]  open_vld;
  logic [AGE_BITS-1:0]  age      [BANK_NUM];
  logic [BANK_BITS-1:0] rr_ptr;
  bank_req_t            slot;

  logic [BANK_NUM-1:0]  starved;
  logic [BANK_NUM-1:0]  hit_set;
  logic [BANK_NUM-1:0]  pick_s, pick_h, pick_a;
  logic                 any_s, any_h, any_a;
  logic [BANK_NUM-1:0]  pick;
  logic                 load_en;
  logic                 grant_any;
  logic [BANK_BITS-1:0] grant_bank;
  logic [BANK_BITS-1:0] next_ptr;
  bank_req_t            req_sel;

  always_comb begin
    starved = '0;
    hit_set = '0;
    for (int g = 0; g < BANK_NUM; g++) begin
      starved[g] = valid_i[g] && (age[g] == AGE_BITS'(STARVE_MAX));
      hit_set[g] = valid_i[g] && open_vld[g] && (ra_i[g] == open_row[g]);
    end
  end

  bank_arbiter_rr_pick #(.N(BANK_NUM)) u_rr_pick_s (.req(starved), .ptr(rr_ptr), .grant(pick_s), .any(any_s));
  bank_arbiter_rr_pick #(.N(BANK_NUM)) u_rr_pick_h (.req(hit_set), .ptr(rr_ptr), .grant(pick_h), .any(any_h));
  bank_arbiter_rr_pick #(.N(BANK_NUM)) u_rr_pick_a (.req(valid_i), .ptr(rr_ptr), .grant(pick_a), .any(any_a));

  always_comb begin
    pick       = any_s ? pick_s : (any_h ? pick_h : pick_a);
    load_en    = !valid_o || ready_i;
    grant_any  = load_en && any_a && !rst;
    ready_o    = grant_any ? pick : '0;
    grant_bank = onehot_to_idx(pick);
    next_ptr   = (grant_bank == BANK_BITS'(BANK_NUM - 1)) ? '0 : grant_bank + BANK_BITS'(1);
    req_sel    = '{req_type: t_i[grant_bank],
                   data:     dq_i[grant_bank],
                   idx:      idx_i[grant_bank],
                   row:      ra_i[grant_bank],
                   column:   ca_i[grant_bank]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o  <= 1'b0;
      slot     <= '0;
      bank_o   <= '0;
      hit_o    <= 1'b0;
      rr_ptr   <= '0;
      open_vld <= '0;
      for (int g = 0; g < BANK_NUM; g++) begin
        open_row[g] <= '0;
        age[g]      <= '0;
      end
    end else begin
      if (grant_any) begin
        valid_o <= 1'b1;
        slot    <= req_sel;
        bank_o  <= grant_bank;
        hit_o   <= hit_set[grant_bank];
        rr_ptr  <= next_ptr;
        open_row[grant_bank] <= ra_i[grant_bank];
        for (int g = 0; g < BANK_NUM; g++) begin
          if (!valid_i[g] || pick[g]) begin
            age[g] <= '0;
          end else if (age[g] != AGE_BITS'(STARVE_MAX)) begin
            age[g] <= age[g] + AGE_BITS'(1);
          end
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
      // A same-cycle grant still reports its hit against the old table,
      // but the flush leaves every row closed afterwards.
      if (flush_i) begin
        open_vld <= '0;
      end else if (grant_any) begin
        open_vld[grant_bank] <= 1'b1;
      end
    end
  end

  assign t_o   = slot.req_type;
  assign dq_o  = slot.data;
  assign idx_o = slot.idx;
  assign ra_o  = slot.row;
  assign ca_o  = slot.column;

endmodule : bank_arbiter
`default_nettype wire

// File: tb/tb_bank_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bank_arbiter : randomized + directed scoreboard bench for bank_arbiter
// Revision: 1.0
// ============================================================================
module tb_bank_arbiter;

  localparam int N = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      valid_i;
  logic [N-1:0][15:0] dq_i;
  logic [N-1:0][5:0]  idx_i;
  logic [N-1:0][15:0] ra_i;
  logic [N-1:0][9:0]  ca_i;
  logic [N-1:0]      t_i;
  logic [N-1:0]      ready_o;
  logic              flush_i;
  logic              ready_i;
  logic              valid_o;
  logic [3:0]        bank_o;
  logic [15:0]       dq_o;
  logic [5:0]        idx_o;
  logic [15:0]       ra_o;
  logic [9:0]        ca_o;
  logic              t_o;
  logic              hit_o;

  always #5 clk = ~clk;

  bank_arbiter dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .dq_i(dq_i), .idx_i(idx_i),
    .ra_i(ra_i), .ca_i(ca_i), .t_i(t_i), .ready_o(ready_o), .flush_i(flush_i),
    .ready_i(ready_i), .valid_o(valid_o), .bank_o(bank_o), .dq_o(dq_o),
    .idx_o(idx_o), .ra_o(ra_o), .ca_o(ca_o), .t_o(t_o), .hit_o(hit_o)
  );

  typedef struct {
    int          bank;
    logic [15:0] dq;
    logic [5:0]  idx;
    logic [15:0] ra;
    logic [9:0]  ca;
    logic        t;
    logic        hit;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: ages, open rows, pointer, slot occupancy
  int          m_age  [N];
  logic [15:0] m_row  [N];
  bit          m_ovld [N];
  int          m_ptr;
  bit          m_valid;
  int          last_grant;
  logic [15:0] ra_set [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_from(input logic [N-1:0] set);
    for (int i = 0; i < N; i++) begin
      if (set[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      m_age[b] = 0; m_row[b] = '0; m_ovld[b] = 0;
    end
    m_ptr = 0; m_valid = 0; last_grant = -1;
    sbq.delete();
  endtask

  // One clock: drive inputs after the edge, predict the grant, update the model.
  task automatic step(input logic [N-1:0] v, input logic fl, input logic rd, input logic r);
    logic [N-1:0] s_set, h_set, exp_ready;
    int g;
    exp_t e;
    @(posedge clk); #2;
    chk("valid_o", valid_o, m_valid);
    valid_i = v; flush_i = fl; ready_i = rd; rst = r;
    for (int b = 0; b < N; b++) begin
      dq_i[b]  = 16'($urandom);
      idx_i[b] = 6'($urandom);
      ca_i[b]  = 10'($urandom);
      t_i[b]   = 1'($urandom);
      ra_i[b]  = ra_set[b];
    end
    #1;
    g = -1;
    if (r) begin
      chk("ready_o_in_reset", ready_o, 0);
      model_reset();
      return;
    end
    if ((!m_valid || rd) && v != 0) begin
      for (int b = 0; b < N; b++) begin
        s_set[b] = v[b] && (m_age[b] == 8);
        h_set[b] = v[b] && m_ovld[b] && (m_row[b] == ra_set[b]);
      end
      g = (s_set != 0) ? rr_from(s_set) : (h_set != 0) ? rr_from(h_set) : rr_from(v);
    end
    exp_ready = (g >= 0) ? (N'(1) << g) : '0;
    chk("ready_o", ready_o, exp_ready);
    if (g >= 0) begin
      e = '{bank: g, dq: dq_i[g], idx: idx_i[g], ra: ra_set[g], ca: ca_i[g], t: t_i[g],
            hit: (m_ovld[g] && m_row[g] == ra_set[g])};
      sbq.push_back(e);
      for (int b = 0; b < N; b++) begin
        if (!v[b] || b == g) m_age[b] = 0;
        else if (m_age[b] < 8) m_age[b]++;
      end
      m_ptr = (g + 1) % N;
      m_row[g] = ra_set[g];
      m_ovld[g] = 1;
      m_valid = 1;
    end else if (rd) begin
      m_valid = 0;
    end
    if (fl) for (int b = 0; b < N; b++) m_ovld[b] = 0;
    last_grant = g;
  endtask

  // Monitor: a slot entry is consumed in the cycle valid_o & ready_i
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_o && ready_i) begin
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual bank=%0d required none", bank_o);
      end else begin
        e = sbq.pop_front();
        chk("bank_o", bank_o, e.bank);
        chk("dq_o",   dq_o,   e.dq);
        chk("idx_o",  idx_o,  e.idx);
        chk("ra_o",   ra_o,   e.ra);
        chk("ca_o",   ca_o,   e.ca);
        chk("t_o",    t_o,    e.t);
        chk("hit_o",  hit_o,  e.hit);
      end
    end
  end

  initial begin
    logic [15:0] held;
    int found;
    rst = 1'b1; valid_i = '0; flush_i = 1'b0; ready_i = 1'b0;
    dq_i = '0; idx_i = '0; ra_i = '0; ca_i = '0; t_i = '0;
    for (int b = 0; b < N; b++) ra_set[b] = 16'(16'h100 + b);
    model_reset();

    // Reset with every bank requesting
    step('1, 0, 1, 1);
    step('1, 0, 1, 1);
    @(posedge clk); #1;
    chk("reset_valid_o", valid_o, 0);
    chk("reset_hit_o", hit_o, 0);
    chk("reset_fields", {bank_o, dq_o, idx_o, ra_o, ca_o, t_o}, 0);
    chk("reset_ready_o", ready_o, 0);
    step('1, 0, 1, 0);
    chk("first_grant", last_grant, 0);

    // Full load, distinct rows: plain round robin 1..15,0,1
    for (int i = 0; i < 17; i++) begin
      for (int b = 0; b < N; b++) ra_set[b] = 16'(16'h200 + i * N + b);
      step('1, 0, 1, 0);
      chk("rr_order", last_grant, (1 + i) % N);
    end

    // Row hit beats lower-numbered bank, then flush behaviour
    step('1, 0, 1, 1); step('1, 0, 1, 1);
    ra_set[3] = 16'h0012; ra_set[15] = 16'h0200; ra_set[2] = 16'h0055;
    step(N'(1) << 3, 0, 1, 0);
    step(N'(1) << 15, 0, 1, 0);
    step((N'(1) << 3) | (N'(1) << 2), 0, 1, 0);
    chk("hit_first_grant", last_grant, 3);
    step('0, 0, 1, 0);
    chk("hit_first_hit_o", hit_o, 1);
    step(N'(1) << 3, 1, 1, 0);
    step(N'(1) << 3, 0, 1, 0);
    chk("flush_cycle_hit_o", hit_o, 1);
    step('0, 0, 1, 0);
    chk("after_flush_hit_o", hit_o, 0);

    // Starvation: bank 5 misses while 6 and 7 keep hitting
    step('1, 0, 1, 1); step('1, 0, 1, 1);
    ra_set[5] = 16'h0099; ra_set[6] = 16'h0077; ra_set[7] = 16'h0077;
    step(N'(1) << 6, 0, 1, 0);
    step(N'(1) << 7, 0, 1, 0);
    found = 0;
    for (int k = 1; k <= 12 && found == 0; k++) begin
      step((N'(1) << 5) | (N'(1) << 6) | (N'(1) << 7), 0, 1, 0);
      if (last_grant == 5) found = k;
    end
    chk("starve_grant_cycle", found, 9);

    // Back-pressure: slot held, no grants for 4 cycles
    step('1, 0, 0, 0);
    held = dq_o;
    for (int k = 0; k < 4; k++) begin
      step('1, 0, 0, 0);
      chk("stall_ready_o", ready_o, 0);
    end
    chk("stall_hold_dq", dq_o, held);
    step('1, 0, 1, 0);
    chk("stall_release_grant", (last_grant >= 0), 1);

    // Random traffic with a small row pool to create hits
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < N; b++) ra_set[b] = 16'(16'h10 * $urandom_range(1, 4));
      step(N'($urandom) & N'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
    end

    for (int k = 0; k < 3; k++) step('0, 0, 1, 0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bank_arbiter
`default_nettype wire
